// File: rtl/organ_pkg.sv
// rtl/organ_pkg.sv - shared constants, types and key-code encoding for the organ key front end
//
// Purpose : common definitions for the key scan / debounce stage.
// Contents: NKEY, key bit-order bases, select FSM state type, key_code encoding.
package organ_pkg;

  localparam int NKEY         = 14;
  localparam int KEYS_PER_ROW = 7;
  localparam int LOW_BASE     = 0;  // low 1..7    -> bits 0..6
  localparam int MID_BASE     = 7;  // middle 1..7 -> bits 7..13
  localparam int KEY_IDX_W    = $clog2(NKEY);
  localparam int KEY_CODE_W   = 4;

  localparam logic [KEY_CODE_W-1:0] KEY_CODE_NONE = '0;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } sel_state_t;

  // key_code is the selected bit index plus one, so zero is free to mean "none".
  function automatic logic [KEY_CODE_W-1:0] key_code_of(input logic [KEY_IDX_W-1:0] idx);
    return idx + 1'b1;
  endfunction

endpackage

// File: rtl/key_debounce_bit.sv
// rtl/key_debounce_bit.sv - two-flop synchroniser and tick-sampled debouncer for one key
//
// Purpose : turn one asynchronous, bouncing button into a clean `stable` level.
// Ports   : clk_in   - system clock
//           rst      - asynchronous active-low reset
//           i_tick   - shared debounce sample strobe, one clk_in cycle wide
//           i_raw    - raw button level, 1 = pressed, asynchronous
//           o_stable - debounced level
module key_debounce_bit #(
  parameter int DEB_CNT = 20
) (
  input  logic clk_in,
  input  logic rst,
  input  logic i_tick,
  input  logic i_raw,
  output logic o_stable
);

  localparam int CNT_W = $clog2(DEB_CNT + 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_stable;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_inc;

  assign w_cnt_inc = r_cnt + 1'b1;

  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      r_sync1  <= 1'b0;
      r_sync2  <= 1'b0;
      r_stable <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
      if (i_tick) begin
        if (r_sync2 == r_stable) begin
          // Any agreeing sample restarts the run, so a glitch must persist.
          r_cnt <= '0;
        end else if (w_cnt_inc == CNT_W'(DEB_CNT)) begin
          r_stable <= ~r_stable;
          r_cnt    <= '0;
        end else begin
          r_cnt <= w_cnt_inc;
        end
      end
    end
  end

  assign o_stable = r_stable;

endmodule

// File: rtl/key_scan_debounce.sv
// rtl/key_scan_debounce.sv - debounce 14 organ buttons and latch a single one-hot key
//
// Purpose : synchronise and debounce the raw buttons, then select one key
//           (lowest index wins, held until released) for the tone stage.
// Ports   : clk_in    - system clock
//           rst       - asynchronous active-low reset
//           key_raw   - raw buttons, 1 = pressed (bit 0 low 1 .. bit 13 middle 7)
//           Key       - selected key, one-hot or zero, registered
//           key_code  - 0 = none, else selected index + 1, registered
//           key_valid - high while Key is nonzero
//           key_event - one-cycle pulse in the cycle Key takes a new value
module key_scan_debounce
  import organ_pkg::*;
#(
  parameter int TICK_DIV = 6000,
  parameter int DEB_CNT  = 20
) (
  input  logic                  clk_in,
  input  logic                  rst,
  input  logic [NKEY-1:0]       key_raw,
  output logic [NKEY-1:0]       Key,
  output logic [KEY_CODE_W-1:0] key_code,
  output logic                  key_valid,
  output logic                  key_event
);

  localparam int TICK_W = $clog2(TICK_DIV);

  logic [TICK_W-1:0]     r_tick_cnt;
  logic                  w_tick;
  logic [NKEY-1:0]       w_stable;
  logic                  w_any;
  logic [KEY_IDX_W-1:0]  w_low_idx;

  sel_state_t            r_state;
  sel_state_t            w_state_next;
  logic [NKEY-1:0]       r_key;
  logic [NKEY-1:0]       w_key_next;
  logic [KEY_CODE_W-1:0] r_code;
  logic [KEY_CODE_W-1:0] w_code_next;
  logic                  r_valid;
  logic                  r_event;

  // Sample strobe shared by all debouncers.
  assign w_tick = (r_tick_cnt == TICK_W'(TICK_DIV - 1));

  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      r_tick_cnt <= '0;
    end else if (w_tick) begin
      r_tick_cnt <= '0;
    end else begin
      r_tick_cnt <= r_tick_cnt + 1'b1;
    end
  end

  for (genvar g = 0; g < NKEY; g++) begin : g_deb
    key_debounce_bit #(
      .DEB_CNT (DEB_CNT)
    ) u_deb (
      .clk_in   (clk_in),
      .rst      (rst),
      .i_tick   (w_tick),
      .i_raw    (key_raw[g]),
      .o_stable (w_stable[g])
    );
  end

  assign w_any = |w_stable;

  // Priority: the low row beats the middle row, and within a row 1 beats 7.
  // Scanning from the weakest candidate upward leaves the strongest one.
  always_comb begin
    w_low_idx = '0;
    for (int i = KEYS_PER_ROW - 1; i >= 0; i--) begin
      if (w_stable[MID_BASE + i]) w_low_idx = KEY_IDX_W'(MID_BASE + i);
    end
    for (int i = KEYS_PER_ROW - 1; i >= 0; i--) begin
      if (w_stable[LOW_BASE + i]) w_low_idx = KEY_IDX_W'(LOW_BASE + i);
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_key_next   = r_key;
    w_code_next  = r_code;
    case (r_state)
      IDLE: begin
        if (w_any) begin
          w_state_next = HOLD;
          w_key_next   = NKEY'(1) << w_low_idx;
          w_code_next  = key_code_of(w_low_idx);
        end else begin
          w_key_next  = '0;
          w_code_next = KEY_CODE_NONE;
        end
      end
      HOLD: begin
        // Only the latched key matters here; other presses wait for IDLE,
        // which is what produces the one-cycle zero gap between selections.
        if ((w_stable & r_key) == '0) begin
          w_state_next = IDLE;
          w_key_next   = '0;
          w_code_next  = KEY_CODE_NONE;
        end
      end
    endcase
  end

  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_key   <= '0;
      r_code  <= KEY_CODE_NONE;
      r_valid <= 1'b0;
      r_event <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_key   <= w_key_next;
      r_code  <= w_code_next;
      r_valid <= |w_key_next;
      r_event <= (w_key_next != r_key);
    end
  end

  assign Key       = r_key;
  assign key_code  = r_code;
  assign key_valid = r_valid;
  assign key_event = r_event;

endmodule

// File: tb/tb_key_scan_debounce.sv
// tb/tb_key_scan_debounce.sv - self-checking bench for key_scan_debounce
module tb_key_scan_debounce;

  localparam int TICK_DIV = 4;
  localparam int DEB_CNT  = 3;
  localparam int NK       = 14;
  localparam int LAT      = 2 + TICK_DIV + DEB_CNT * TICK_DIV + 1;

  logic          clk_in = 1'b0;
  logic          rst    = 1'b0;
  logic [NK-1:0] key_raw = '0;
  logic [NK-1:0] Key;
  logic [3:0]    key_code;
  logic          key_valid;
  logic          key_event;

  int n_tests = 0;
  int n_fail  = 0;

  key_scan_debounce #(
    .TICK_DIV (TICK_DIV),
    .DEB_CNT  (DEB_CNT)
  ) dut (
    .clk_in    (clk_in),
    .rst       (rst),
    .key_raw   (key_raw),
    .Key       (Key),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_event (key_event)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: each key flips its debounced level once the last DEB_CNT
  // tick samples of the synchronised input all disagree with it; selection
  // keeps one key index until that key's level drops.
  logic [NK-1:0] m_s1, m_s2, m_stable, m_key;
  logic [NK-1:0] m_hist[$];
  int            m_tc, m_sel, m_code;
  logic          m_event;

  initial begin
    m_s1 = '0; m_s2 = '0; m_stable = '0; m_key = '0;
    m_tc = 0; m_sel = -1; m_code = 0; m_event = 1'b0;
    forever begin
      @(posedge clk_in or negedge rst);
      if (!rst) begin
        m_s1 = '0; m_s2 = '0; m_stable = '0; m_key = '0;
        m_hist.delete();
        m_tc = 0; m_sel = -1; m_code = 0; m_event = 1'b0;
      end else begin
        logic [NK-1:0] prev_key;
        logic [NK-1:0] new_stable;
        logic          all_diff;
        prev_key = m_key;
        if (m_sel < 0) begin
          for (int k = NK - 1; k >= 0; k--) if (m_stable[k]) m_sel = k;
        end else if (!m_stable[m_sel]) begin
          m_sel = -1;
        end
        m_key   = (m_sel < 0) ? '0 : (NK'(1) << m_sel);
        m_code  = m_sel + 1;
        m_event = (m_key != prev_key);
        if (m_tc == TICK_DIV - 1) begin
          m_hist.push_back(m_s2);
          if (m_hist.size() > DEB_CNT) void'(m_hist.pop_front());
          new_stable = m_stable;
          if (m_hist.size() == DEB_CNT) begin
            for (int k = 0; k < NK; k++) begin
              all_diff = 1'b1;
              foreach (m_hist[j]) if (m_hist[j][k] == m_stable[k]) all_diff = 1'b0;
              if (all_diff) new_stable[k] = ~m_stable[k];
            end
          end
          m_stable = new_stable;
        end
        m_tc = (m_tc + 1) % TICK_DIV;
        m_s2 = m_s1;
        m_s1 = key_raw;
      end
    end
  end

  always @(negedge clk_in) begin
    check("mdl_key",   32'(Key),       32'(m_key));
    check("mdl_code",  32'(key_code),  32'(m_code));
    check("mdl_valid", 32'(key_valid), 32'(m_key != '0));
    check("mdl_event", 32'(key_event), 32'(m_event));
  end

  task automatic wait_key(input logic [NK-1:0] exp, input int budget,
                          output int events);
    int cycles;
    cycles = 0;
    events = 0;
    do begin
      @(negedge clk_in);
      cycles++;
      if (key_event) events++;
    end while (Key !== exp && cycles < budget);
  endtask

  task automatic idle_cycles(input int n, output int events, output int nonzero);
    events = 0;
    nonzero = 0;
    repeat (n) begin
      @(negedge clk_in);
      if (key_event) events++;
      if (Key != '0) nonzero++;
    end
  endtask

  initial begin
    int ev, nz, early;
    logic [NK-1:0] rv;

    // Reset with random inputs
    repeat (6) begin
      @(negedge clk_in);
      key_raw = NK'($urandom);
      check("rst_key",   32'(Key),       32'h0);
      check("rst_code",  32'(key_code),  32'h0);
      check("rst_valid", 32'(key_valid), 32'h0);
      check("rst_event", 32'(key_event), 32'h0);
    end
    key_raw = '0;
    @(negedge clk_in);
    rst = 1'b1;

    // Bounce on bit 2: five-cycle half periods never give DEB_CNT agreeing ticks
    ev = 0; nz = 0;
    for (int c = 0; c < 60; c++) begin
      if (c % 5 == 0) key_raw[2] = ~key_raw[2];
      @(negedge clk_in);
      if (key_event) ev++;
      if (Key != '0) nz++;
    end
    check("bounce_key_nz", 32'(nz), 32'h0);
    check("bounce_event",  32'(ev), 32'h0);
    key_raw = '0;
    idle_cycles(20, ev, nz);

    // Clean press and release of middle 1
    key_raw = 14'h0080;
    wait_key(14'h0080, LAT, ev);
    check("press_key",   32'(Key),       32'h0080);
    check("press_code",  32'(key_code),  32'd8);
    check("press_valid", 32'(key_valid), 32'h1);
    check("press_event", 32'(ev),        32'd1);
    key_raw = '0;
    wait_key(14'h0000, LAT, ev);
    check("release_key",   32'(Key),       32'h0);
    check("release_valid", 32'(key_valid), 32'h0);
    check("release_event", 32'(ev),        32'd1);
    idle_cycles(20, ev, nz);

    // Simultaneous press: lowest index wins
    key_raw = 14'h2011;
    wait_key(14'h0001, LAT, ev);
    check("simul_key",  32'(Key),      32'h0001);
    check("simul_code", 32'(key_code), 32'd1);

    // Hold priority: extra presses ignored, next key after one zero cycle
    key_raw = 14'h0011;
    idle_cycles(2 * LAT, ev, nz);
    check("hold_key",   32'(Key), 32'h0001);
    check("hold_event", 32'(ev),  32'd0);
    key_raw = 14'h0010;
    wait_key(14'h0000, LAT, ev);
    check("gap_key",   32'(Key),       32'h0);
    check("gap_event", 32'(key_event), 32'h1);
    @(negedge clk_in);
    check("next_key",   32'(Key),       32'h0010);
    check("next_code",  32'(key_code),  32'd5);
    check("next_event", 32'(key_event), 32'h1);

    // Reset mid-hold
    key_raw = 14'h0040;
    wait_key(14'h0040, 3 * LAT, ev);
    check("pre_rst_key", 32'(Key), 32'h0040);
    @(posedge clk_in); #1;
    rst = 1'b0;
    #1;
    check("rst_async_key",   32'(Key),       32'h0);
    check("rst_async_valid", 32'(key_valid), 32'h0);
    @(posedge clk_in); #1;
    rst = 1'b1;
    early = 0;
    @(negedge clk_in);
    if (Key != '0) early++;
    repeat (12) begin
      @(negedge clk_in);
      if (Key != '0) early++;
    end
    check("rst_no_early", 32'(early), 32'h0);
    @(negedge clk_in);
    check("rst_relatch_key",   32'(Key),       32'h0040);
    check("rst_relatch_code",  32'(key_code),  32'd7);
    check("rst_relatch_event", 32'(key_event), 32'h1);

    // Randomised traffic against the model
    for (int s = 0; s < 250; s++) begin
      case ($urandom_range(0, 9))
        0, 1, 2:    rv = '0;
        3, 4, 5, 6: rv = NK'(1) << $urandom_range(0, NK - 1);
        7, 8:       rv = (NK'(1) << $urandom_range(0, NK - 1)) |
                         (NK'(1) << $urandom_range(0, NK - 1));
        default:    rv = NK'($urandom);
      endcase
      key_raw = rv;
      if ($urandom_range(0, 39) == 0) begin
        @(posedge clk_in); #1;
        rst = 1'b0;
        @(posedge clk_in); #1;
        rst = 1'b1;
      end
      repeat ($urandom_range(1, 30)) @(negedge clk_in);
    end

    @(negedge clk_in);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/key_scan_debounce.md
# key_scan_debounce

Front-end stage of the electronic organ: synchronises and debounces the 14 raw push-buttons (low 1–7, middle 1–7) and delivers a clean, registered, one-hot or all-zero `Key` word to the tone/auto-play stage. A held key stays latched until it is released, and simultaneous presses resolve deterministically. A one-cycle event pulse and a binary key code are also produced for the display and recording logic.

## Interface
- `TICK_DIV`, 6000: `clk_in` cycles per debounce sample tick. Legal range is 2 or more.
- `DEB_CNT`, 20: number of consecutive agreeing ticks needed to accept a level change. Legal range is 1 or more.
- `clk_in`  input  1  system clock.
- `rst`  input  1  asynchronous, active-low reset.
- `key_raw`  input  14  raw buttons, 1 = pressed, asynchronous to `clk_in`. Bit 0 is low 1, bit 6 is low 7, bit 7 is middle 1, bit 13 is middle 7.
- `Key`  output  14  selected key, one-hot, or zero when no key is selected. Registered.
- `key_code`  output  4  0 = none, 1..14 = selected bit index + 1. Registered.
- `key_valid`  output  1  high while `Key` is nonzero.
- `key_event`  output  1  one-cycle pulse whenever `Key` changes value.

## Operation
- **Synchroniser:** a 2-flop synchroniser on each `key_raw` bit.
- **Tick generator:** a counter runs 0..TICK_DIV-1 and wraps. `tick` is high for one cycle when the count equals TICK_DIV-1. Counter width is $clog2(TICK_DIV).
- **Per-key debouncer:** each key has a `stable` bit and a counter of width $clog2(DEB_CNT+1).
  - On a tick where synced ≠ stable: the counter increments.
  - When the counter reaches DEB_CNT: `stable` toggles and the counter clears.
  - On any tick where synced = stable: the counter clears.
  - A pulse or glitch shorter than DEB_CNT ticks therefore never reaches `stable`.
- **Select FSM, IDLE state:**
  - If any `stable` bit is 1, latch the lowest-index pressed key and go to HOLD.
  - Otherwise `Key` = 0.
- **Select FSM, HOLD state:**
  - While the latched key's `stable` bit = 1, hold `Key` unchanged. Presses of other keys are ignored.
  - When the latched key's `stable` bit = 0, set `Key` to 0 and go to IDLE.
  - If other keys are still stable-pressed at that point, the next key is selected one cycle later from IDLE. `Key` is 0 for exactly one cycle between the two selections.
- **Outputs:** `key_code` and `key_valid` always match `Key` in the same cycle. `key_event` = registered (Key_next ≠ Key).

## Timing
- **Reset values:** all outputs 0. Synchronisers, counters and `stable` bits are cleared; the FSM is in IDLE.
- **Reset mid-operation:** takes effect immediately and asynchronously. After release, a still-held key must debounce again from zero.
- **Latency, press to `Key`:** 2 synchroniser cycles, plus up to TICK_DIV cycles of tick alignment, plus DEB_CNT·TICK_DIV, plus 1 register cycle. Release latency is the same.
- **`key_event`:** asserted in the same cycle as the new `Key` value. Never asserted for two consecutive cycles except across a release-then-select transition.
- **Simultaneous stable presses in the same cycle:** the lowest index wins, i.e. low takes priority over middle and 1 over 7.
- **Release and a new press in the same cycle:** handled as release first. The new key appears after the one-cycle zero gap.

## Structure
- **Shared package** (`organ_pkg`) holds:
  - `NKEY` = 14
  - the key bit-order constants (LOW_BASE = 0, MID_BASE = 7)
  - the FSM enum {IDLE, HOLD}
  - the `key_code` encoding
- **Sub-module** `key_debounce_bit`: synchroniser, counter and `stable` for one key. It is instantiated 14 times; the tick is shared.
- The top level contains the tick generator, the priority encoder and the FSM.

## Test plan
All scenarios use TICK_DIV=4 and DEB_CNT=3.
- **Reset and bounce rejection:** with `rst`=0 and random `key_raw`, all outputs are 0. After release, toggle bit 2 every 5 cycles; `Key` stays 0 and `key_event` never fires.
- **Clean press and release:** hold `key_raw`=14'h0080 (middle 1). Within 2+4+12+1 cycles `Key`=14'h0080, `key_code`=8, `key_valid`=1, with one `key_event`. Release it; `Key` returns to 0 with one `key_event`.
- **Simultaneous press:** set `key_raw`=14'h2011. `Key`=14'h0001 and `key_code`=1.
- **Hold priority:** with bit 0 latched, additionally press bit 4; `Key` is unchanged. Release bit 0; `Key`=0 for exactly one cycle, then 14'h0010, with two `key_event` pulses.
- **Reset mid-hold:** with `Key`=14'h0040, pulse `rst` low for 1 cycle. `Key` is 0 immediately, then re-latches 14'h0040 only after the full debounce latency.
